// File: rtl/hermes_pkg.sv
// Shared types and constants for the Hermes local-port packet injector.
package hermes_pkg;

  localparam int HERMES_MIN_FLIT_SIZE = 20;

  // One-hot framing states; any other encoding is treated as illegal.
  typedef enum logic [2:0] {
    ST_HEADER  = 3'b001,
    ST_SIZE    = 3'b010,
    ST_PAYLOAD = 3'b100
  } frame_state_e;

endpackage

// File: rtl/hermes_flit_reg.sv
// Single-entry output register toward the router: holds one flit plus its
// valid bit and frees itself on credit, allowing reload in the delivery cycle.
module hermes_flit_reg #(
  parameter int FLIT_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 credit_i,
  output logic                 tx_o,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 ready_o
);

  logic                 tx_q, tx_d;
  logic [FLIT_SIZE-1:0] data_q, data_d;

  always_comb begin
    tx_d   = tx_q;
    data_d = data_q;
    if (load_i) begin
      tx_d   = 1'b1;
      data_d = data_i;
    end else if (tx_q && credit_i) begin
      tx_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q   <= 1'b0;
      data_q <= '0;
    end else begin
      tx_q   <= tx_d;
      data_q <= data_d;
    end
  end

  // Empty, or emptying this cycle, means a new flit can be taken.
  assign ready_o = !rst_i && (!tx_q || credit_i);
  assign tx_o    = tx_q;
  assign data_o  = data_q;

endmodule

// File: rtl/hermes_injector.sv
// Hermes local-port packet injector: header/size/payload framing in front of
// a credit-based output register. Optional counters: HERMES_INJECTOR_STATS_EN.
module hermes_injector
  import hermes_pkg::*;
#(
  parameter int FLIT_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pkt_valid_i,
  input  logic [FLIT_SIZE-1:0] pkt_data_i,
  output logic                 pkt_ready_o,
  output logic                 tx_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 credit_i,
  output logic                 busy_o,
  output logic                 err_o
`ifdef HERMES_INJECTOR_STATS_EN
  ,
  output logic [31:0]          pkt_cnt_o,
  output logic [31:0]          flit_cnt_o
`endif
);

  if (FLIT_SIZE < HERMES_MIN_FLIT_SIZE) begin : g_size_check
    $error("hermes_injector: FLIT_SIZE below minimum");
  end

  frame_state_e         state_q, state_d;
  logic [FLIT_SIZE-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 accept;

  assign accept = pkt_valid_i && pkt_ready_o;

  hermes_flit_reg #(
    .FLIT_SIZE(FLIT_SIZE)
  ) u_flit_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (accept),
    .data_i   (pkt_data_i),
    .credit_i (credit_i),
    .tx_o     (tx_o),
    .data_o   (data_o),
    .ready_o  (pkt_ready_o)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_HEADER: begin
        if (accept) state_d = ST_SIZE;
      end
      ST_SIZE: begin
        if (accept) begin
          if (pkt_data_i == '0) begin
            state_d = ST_HEADER;
            err_d   = 1'b1;
          end else begin
            cnt_d   = pkt_data_i;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        // The last payload flit leaves the counter at 1 rather than 0.
        if (accept) begin
          if (cnt_q <= FLIT_SIZE'(1)) state_d = ST_HEADER;
          else                        cnt_d   = cnt_q - FLIT_SIZE'(1);
        end
      end
      default: state_d = ST_HEADER;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_HEADER;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = (state_q != ST_HEADER) || tx_o;
  assign err_o  = err_q;

`ifdef HERMES_INJECTOR_STATS_EN
  logic [31:0] pkt_cnt_q, flit_cnt_q;
  logic        pkt_done;

  assign pkt_done = accept && (state_q != ST_HEADER) && (state_d == ST_HEADER);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      if (pkt_done)          pkt_cnt_q  <= pkt_cnt_q + 32'd1;
      if (tx_o && credit_i)  flit_cnt_q <= flit_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign flit_cnt_o = flit_cnt_q;
`endif

endmodule

// File: tb/tb_hermes_injector.sv
// Directed and randomized bench for hermes_injector; the reference model is
// the ordered list of offered flits plus packet/flit totals per reset epoch.
module tb_hermes_injector;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        pkt_valid_i = 1'b0;
  logic [31:0] pkt_data_i = '0;
  logic        credit_i = 1'b1;
  wire         pkt_ready_o, tx_o, busy_o, err_o;
  wire  [31:0] data_o;
`ifdef HERMES_INJECTOR_STATS_EN
  wire  [31:0] pkt_cnt_o, flit_cnt_o;
`endif

  hermes_injector #(.FLIT_SIZE(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .pkt_valid_i (pkt_valid_i),
    .pkt_data_i  (pkt_data_i),
    .pkt_ready_o (pkt_ready_o),
    .tx_o        (tx_o),
    .data_o      (data_o),
    .credit_i    (credit_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
`ifdef HERMES_INJECTOR_STATS_EN
    ,
    .pkt_cnt_o   (pkt_cnt_o),
    .flit_cnt_o  (flit_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          err_seen = 0;
  bit          rand_credit = 1'b0;
  logic [31:0] dlv_q[$];
  int          dlv_cyc[$];
  logic [31:0] exp_q[$];
  int          exp_pkts = 0;
  int          exp_flits = 0;

  always @(posedge clk) cyc++;

  // Inputs only change at posedge+1, so negedge values hold through the edge.
  always @(negedge clk) begin
    if (!rst_i && tx_o && credit_i) begin
      dlv_q.push_back(data_o);
      dlv_cyc.push_back(cyc);
    end
    if (err_o) err_seen++;
  end

  always @(posedge clk) begin
    if (rand_credit) begin
      #1;
      credit_i = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    pkt_valid_i = 1'b1;
    pkt_data_i  = d;
    forever begin
      @(negedge clk);
      if (pkt_ready_o) break;
      n++;
      if (n > 200) begin
        check("send_ready_timeout", pkt_ready_o, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    pkt_valid_i = 1'b0;
  endtask

  task automatic send_packet(input logic [31:0] h, input int s, input logic [31:0] base, input bit gaps);
    send(h);
    exp_q.push_back(h);
    if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    send(32'(s));
    exp_q.push_back(32'(s));
    for (int i = 0; i < s; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(base + 32'(i));
      exp_q.push_back(base + 32'(i));
    end
    exp_pkts++;
    exp_flits += s + 2;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < 1000);
    check("drain_busy", busy_o, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, dlv_q.size(), exp_q.size());
    n = (dlv_q.size() < exp_q.size()) ? dlv_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_flit%0d", tag, i), dlv_q[i], exp_q[i]);
    dlv_q.delete();
    dlv_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_stats(input string tag);
`ifdef HERMES_INJECTOR_STATS_EN
    check({tag, "_pkt_cnt"}, pkt_cnt_o, exp_pkts);
    check({tag, "_flit_cnt"}, flit_cnt_o, exp_flits);
`else
    check({tag, "_idle_busy"}, busy_o, 1'b0);
`endif
  endtask

  initial begin
    int s;
    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready_low", pkt_ready_o, 1'b0);
    check("rst_tx", tx_o, 1'b0);
    check("rst_data", data_o, 32'h0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_ready", pkt_ready_o, 1'b1);
    check_stats("reset");
    @(posedge clk); #1;

    // Single packet, credit always high
    send_packet(32'h0101, 3, 32'hA, 1'b0);
    @(negedge clk);
    check("t1_last_busy", busy_o, 1'b1);
    check("t1_last_data", data_o, 32'hC);
    @(negedge clk);
    check("t1_busy_fall", busy_o, 1'b0);
    @(posedge clk); #1;
    if (dlv_cyc.size() == 5) check("t1_consecutive", dlv_cyc[4] - dlv_cyc[0], 4);
    compare_stream("t1");

    // Credit stall right after the size flit
    send(32'h0101); exp_q.push_back(32'h0101);
    send(32'd3);    exp_q.push_back(32'd3);
    credit_i = 1'b0;
    pkt_valid_i = 1'b1;
    pkt_data_i = 32'hA;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t2_hold_data%0d", k), data_o, 32'd3);
      check($sformatf("t2_hold_tx%0d", k), tx_o, 1'b1);
      check($sformatf("t2_ready_low%0d", k), pkt_ready_o, 1'b0);
      @(posedge clk); #1;
    end
    credit_i = 1'b1;
    send(32'hA); exp_q.push_back(32'hA);
    send(32'hB); exp_q.push_back(32'hB);
    send(32'hC); exp_q.push_back(32'hC);
    exp_pkts++;
    exp_flits += 5;
    drain();
    compare_stream("t2");

    // Zero size flit
    send_packet(32'h0202, 0, 32'h0, 1'b0);
    @(negedge clk);
    check("t3_err_pulse", err_o, 1'b1);
    @(negedge clk);
    check("t3_err_clear", err_o, 1'b0);
    @(posedge clk); #1;
    send_packet(32'h0303, 1, 32'hD, 1'b0);
    drain();
    compare_stream("t3");
    check("t3_err_count", err_seen, 1);
    check_stats("t3");

    // Two packets back-to-back
    send_packet(32'h0404, 1, 32'h11, 1'b0);
    send_packet(32'h0505, 2, 32'h21, 1'b0);
    drain();
    check("t4_count", dlv_cyc.size(), 7);
    if (dlv_cyc.size() == 7) check("t4_no_bubble", dlv_cyc[6] - dlv_cyc[0], 6);
    compare_stream("t4");

    // Reset mid-packet
    send(32'h0606); exp_q.push_back(32'h0606);
    send(32'd5);    exp_q.push_back(32'd5);
    send(32'h31);   exp_q.push_back(32'h31);
    send(32'h32);
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("t5_tx_drop", tx_o, 1'b0);
    check("t5_busy_drop", busy_o, 1'b0);
    rst_i = 1'b0;
    exp_pkts = 0;
    exp_flits = 0;
    compare_stream("t5_pre");
    send_packet(32'h0707, 1, 32'h41, 1'b0);
    drain();
    compare_stream("t5_post");
    check_stats("t5");

    // Random credit over 100 packets
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_pkts = 0;
    exp_flits = 0;
    err_seen = 0;
    rand_credit = 1'b1;
    for (int p = 0; p < 100; p++) begin
      s = $urandom_range(1, 16);
      send_packet($urandom, s, $urandom, 1'b1);
    end
    rand_credit = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    credit_i = 1'b1;
    drain();
    compare_stream("t6");
    check("t6_no_err", err_seen, 0);
    check_stats("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
